// File: rtl/seq_signed_div.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, restoring algorithm on
// magnitudes, one quotient bit per clock, sign fix-up applied when results are published.
module seq_signed_div #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   shq_q;
  logic [N-1:0]   dvs_q;
  logic [N-1:0]   rem_q;
  logic           neg_q_q;
  logic           neg_r_q;
  logic           dz_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   quotient_q;
  logic [N-1:0]   remainder_q;
  logic           div_zero_q;
  logic           overflow_q;

  logic           accept;
  logic           last_iter;
  logic [W-1:0]   dvd_mag;
  logic [N-1:0]   dvs_mag;
  logic [N:0]     trial;
  logic [N:0]     diff;
  logic           ge;
  logic [W-1:0]   q_fin;
  logic [N-1:0]   r_fin;

  always_comb begin
    // done_q is still high in the first Idle cycle after a result; starts there are dropped.
    accept    = (state_q == StIdle) && start && !done_q;
    last_iter = (cnt_q == CW'(W - 1));

    // Two's-complement negate keeps -2^(W-1) as the unsigned value 2^(W-1).
    dvd_mag = dividend[W-1] ? (~dividend + W'(1)) : dividend;
    dvs_mag = divisor[N-1]  ? (~divisor + N'(1))  : divisor;

    trial = {rem_q, shq_q[W-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = (trial >= {1'b0, dvs_q});

    q_fin = neg_q_q ? (~shq_q + W'(1)) : shq_q;
    r_fin = neg_r_q ? (~rem_q + N'(1)) : rem_q;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (divisor == '0) ? StDone : StCalc;
      StCalc:  if (last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shq_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shq_q   <= dvd_mag;
            dvs_q   <= dvs_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= dividend[W-1] ^ divisor[N-1];
            neg_r_q <= dividend[W-1];
            dz_q    <= (divisor == '0);
            busy_q  <= (divisor != '0);
          end
        end
        StCalc: begin
          shq_q <= {shq_q[W-2:0], ge};
          rem_q <= ge ? diff[N-1:0] : trial[N-1:0];
          cnt_q <= cnt_q + CW'(1);
        end
        StDone: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (dz_q) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b1;
            overflow_q  <= 1'b0;
          end else begin
            quotient_q  <= q_fin;
            remainder_q <= r_fin;
            div_zero_q  <= 1'b0;
            // Only a positive quotient of magnitude 2^(W-1) is unrepresentable.
            overflow_q  <= !neg_q_q && shq_q[W-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div (N=4): directed sign/overflow/zero/abort cases
// plus a shuffled sweep of every operand pair against an integer-arithmetic model.
module tb_seq_signed_div;

  localparam int N = 4;
  localparam int W = 2 * N;

  typedef logic [W+N+1:0] res_t;  // {quotient, remainder, div_zero, overflow}

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         overflow;

  int vectors     = 0;
  int miscompares = 0;

  seq_signed_div #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Truncating signed division from plain integer arithmetic.
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [N-1:0] b);
    int ai, bi, qi, ri;
    logic ov;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return {W'(0), N'(0), 1'b1, 1'b0};
    qi = ai / bi;
    ri = ai % bi;
    ov = (qi > (2 ** (W - 1)) - 1);
    return {W'(qi), N'(ri), 1'b0, ov};
  endfunction

  // Issues one division (start held for hold extra edges first) and observes the protocol.
  task automatic run_div(input logic [W-1:0] a, input logic [N-1:0] b, input int hold,
                         input bit tail, output int lat, output res_t res,
                         output bit proto_bad);
    res_t held;
    proto_bad = 1'b0;
    lat       = -1;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) proto_bad = 1'b1;
    end
    @(posedge clk); #1;
    if (busy !== (b != '0)) proto_bad = 1'b1;
    held = {quotient, remainder, div_zero, overflow};
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = N'($urandom);
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        if (busy !== 1'b0) proto_bad = 1'b1;
      end else if (busy !== (b != '0) || {quotient, remainder, div_zero, overflow} !== held) begin
        proto_bad = 1'b1;
      end
    end
    res = {quotient, remainder, div_zero, overflow};
    if (tail) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || {quotient, remainder, div_zero, overflow} !== res)
        proto_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [W+N+3:0] obs;
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = W'(100);
    divisor  = N'(7);
    repeat (2) @(posedge clk);
    #1;
    obs = {busy, done, quotient, remainder, div_zero, overflow};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h, want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    res_t res, exp_res;
    bit pb;
    exp_res = {W'(14), N'(2), 2'b00};
    run_div(W'(100), N'(7), 0, 1'b1, lat, res, pb);
    vectors += 3;
    if (lat !== 9) begin miscompares++; $display("FAIL basic latency: got %0d, want 9", lat); end
    if (res !== exp_res) begin
      miscompares++; $display("FAIL basic result: got %h, want %h", res, exp_res);
    end
    if (pb) begin miscompares++; $display("FAIL basic protocol: got 1, want 0"); end
  endtask

  task automatic test_signs();
    int ta[5] = '{-100, 100, -100, -128, 0};
    int tb[5] = '{7, -7, -7, 1, -3};
    int tq[5] = '{-14, -14, 14, -128, 0};
    int tr[5] = '{-2, 2, -2, 0, 0};
    int lat;
    res_t res, exp_res;
    bit pb;
    for (int i = 0; i < 5; i++) begin
      exp_res = {W'(tq[i]), N'(tr[i]), 2'b00};
      run_div(W'(ta[i]), N'(tb[i]), 0, 1'b1, lat, res, pb);
      vectors += 2;
      if (res !== exp_res || lat !== 9) begin
        miscompares++;
        $display("FAIL signs %0d/%0d: got %h lat %0d, want %h lat 9", ta[i], tb[i], res, lat,
                 exp_res);
      end
      if (pb) begin miscompares++; $display("FAIL signs protocol %0d: got 1, want 0", i); end
    end
  endtask

  task automatic test_overflow();
    int lat;
    res_t res, exp_res;
    bit pb;
    exp_res = {W'(-128), N'(0), 1'b0, 1'b1};
    run_div(W'(-128), N'(-1), 0, 1'b1, lat, res, pb);
    vectors += 2;
    if (res !== exp_res || lat !== 9) begin
      miscompares++;
      $display("FAIL overflow result: got %h lat %0d, want %h lat 9", res, lat, exp_res);
    end
    if (pb) begin miscompares++; $display("FAIL overflow protocol: got 1, want 0"); end
  endtask

  task automatic test_div_zero();
    int lat;
    res_t res, exp_res;
    bit pb;
    exp_res = {W'(0), N'(0), 1'b1, 1'b0};
    run_div(W'(37), N'(0), 0, 1'b1, lat, res, pb);
    vectors += 3;
    if (lat !== 1) begin miscompares++; $display("FAIL divzero latency: got %0d, want 1", lat); end
    if (res !== exp_res) begin
      miscompares++; $display("FAIL divzero result: got %h, want %h", res, exp_res);
    end
    if (pb) begin miscompares++; $display("FAIL divzero busy/protocol: got 1, want 0"); end
  endtask

  // Start held high from the done cycle: that edge is ignored, the next one is accepted.
  task automatic test_back_to_back();
    int lat;
    res_t res, exp_res;
    bit pb;
    run_div(W'(50), N'(3), 0, 1'b0, lat, res, pb);
    exp_res = {W'(14), N'(-2), 2'b00};
    run_div(W'(-100), N'(-7), 1, 1'b1, lat, res, pb);
    vectors += 2;
    if (res !== exp_res || lat !== 9) begin
      miscompares++;
      $display("FAIL back_to_back result: got %h lat %0d, want %h lat 9", res, lat, exp_res);
    end
    if (pb) begin miscompares++; $display("FAIL back_to_back protocol: got 1, want 0"); end
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    logic [W+N+3:0] obs;
    int lat;
    res_t res, exp_res;
    bit pb;
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(50);
    divisor  = N'(3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
      if (c == 2) begin start = 1'b1; dividend = W'(20); divisor = N'(4); end
      if (c == 3) start = 1'b0;
      if (c == 4) rst_n = 1'b0;
    end
    obs = {busy, done, quotient, remainder, div_zero, overflow};
    vectors += 2;
    if (saw_done) begin miscompares++; $display("FAIL abort done pulse: got 1, want 0"); end
    if (obs !== '0) begin miscompares++; $display("FAIL abort outputs: got %h, want 0", obs); end
    rst_n = 1'b1;
    exp_res = {W'(5), N'(0), 2'b00};
    run_div(W'(20), N'(4), 0, 1'b1, lat, res, pb);
    vectors += 2;
    if (res !== exp_res || lat !== 9) begin
      miscompares++;
      $display("FAIL abort restart: got %h lat %0d, want %h lat 9", res, lat, exp_res);
    end
    if (pb) begin miscompares++; $display("FAIL abort restart protocol: got 1, want 0"); end
  endtask

  task automatic test_sweep();
    int order[4096];
    int j, tmp, lat, exp_lat;
    logic [11:0] idx;
    res_t res, exp_res;
    bit pb;
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      idx     = 12'(order[i]);
      exp_res = ref_div(idx[11:4], idx[3:0]);
      exp_lat = (idx[3:0] == '0) ? 1 : 9;
      run_div(idx[11:4], idx[3:0], 0, 1'b1, lat, res, pb);
      vectors += 3;
      if (res !== exp_res) begin
        miscompares++;
        $display("FAIL sweep %h/%h result: got %h, want %h", idx[11:4], idx[3:0], res, exp_res);
      end
      if (lat !== exp_lat) begin
        miscompares++;
        $display("FAIL sweep %h/%h latency: got %0d, want %0d", idx[11:4], idx[3:0], lat,
                 exp_lat);
      end
      if (pb) begin
        miscompares++;
        $display("FAIL sweep %h/%h protocol: got 1, want 0", idx[11:4], idx[3:0]);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
